// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store unit. Issues one req/ack transaction per
//            instruction on the data-memory port, stalls the pipeline while it
//            is outstanding, and returns a sign/zero-extended load result.
//            Optional macro MISALIGN_TRAP_EN: trap misaligned half/word
//            accesses instead of issuing them.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_W      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        pipe_en,
    input  logic [31:0] addr_MEM,
    input  logic [31:0] wdata_MEM,
    input  logic [2:0]  func3_MEM,
    input  logic        memR_en_MEM,
    input  logic        memW_en_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_MEM,
    output logic        load_valid_MEM,
    output logic        stall_MEM,
    output logic        timeout_err,
    output logic        misalign_err
);

    localparam logic [TIMEOUT_W-1:0] c_tmo_last = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_req;
    logic                 r_we;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_be;
    logic [31:0]          r_load_data;
    logic                 r_load_valid;
    logic                 r_timeout_err;
    logic                 r_misalign_err;
    logic [TIMEOUT_W-1:0] r_tmo_cnt;
    logic [2:0]           r_func3;      // size/sign of the access in flight
    logic [1:0]           r_lane;       // byte offset of the access in flight
    logic                 r_is_load;
    logic                 r_kill;       // flush seen while the bus was busy

    logic                 w_access;
    logic                 w_trap;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_ext;

    // A store wins when both enables are set.
    assign w_access = memR_en_MEM | memW_en_MEM;

`ifdef MISALIGN_TRAP_EN
    // Half needs addr[0]=0, word needs addr[1:0]=0; func3[1] covers all word codes.
    assign w_trap = ((func3_MEM[1:0] == 2'b01) & addr_MEM[0])
                  | (func3_MEM[1] & (addr_MEM[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    // Store lane steering: byte enables and replicated write data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_MEM;
        if (memW_en_MEM) begin
            case (func3_MEM[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addr_MEM[1:0];
                    w_wdata = {4{wdata_MEM[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {addr_MEM[1], 1'b0};
                    w_wdata = {2{wdata_MEM[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = wdata_MEM;
                end
            endcase
        end
    end

    // Load lane selection and sign/zero extension of the returned word.
    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_func3[1:0])
            2'b00:   w_ext = r_func3[2] ? {24'h000000, w_byte}
                                        : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ext = r_func3[2] ? {16'h0000, w_half}
                                        : {{16{w_half[15]}}, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    // Main access FSM; all bus fields and results are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= 32'h0;
            r_wdata        <= 32'h0;
            r_be           <= 4'h0;
            r_load_data    <= 32'h0;
            r_load_valid   <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_tmo_cnt      <= '0;
            r_func3        <= 3'b000;
            r_lane         <= 2'b00;
            r_is_load      <= 1'b0;
            r_kill         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access && !flush) begin
                        if (w_trap) begin
                            r_misalign_err <= 1'b1;
                            r_load_data    <= 32'h0;
                            r_load_valid   <= 1'b0;
                            r_state        <= ST_DONE;
                        end else begin
                            r_req     <= 1'b1;
                            r_we      <= memW_en_MEM;
                            r_addr    <= {addr_MEM[31:2], 2'b00};
                            r_wdata   <= w_wdata;
                            r_be      <= w_be;
                            r_func3   <= func3_MEM;
                            r_lane    <= addr_MEM[1:0];
                            r_is_load <= ~memW_en_MEM;
                            r_kill    <= 1'b0;
                            r_tmo_cnt <= '0;
                            r_state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // A request may not be withdrawn; a flush only suppresses the result.
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (dmem_ack) begin
                        r_req <= 1'b0;
                        if (r_kill || flush) begin
                            r_state <= ST_IDLE;
                        end else begin
                            if (r_is_load) begin
                                r_load_data <= w_ext;
                            end
                            r_load_valid <= r_is_load;
                            r_state      <= ST_DONE;
                        end
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        r_req <= 1'b0;
                        if (r_kill || flush) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_timeout_err <= 1'b1;
                            r_load_data   <= 32'h0;
                            r_load_valid  <= 1'b0;
                            r_state       <= ST_DONE;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Wait for EX/MEM to move on so the same instruction is not re-issued.
                    if (pipe_en || flush) begin
                        r_load_valid   <= 1'b0;
                        r_timeout_err  <= 1'b0;
                        r_misalign_err <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_MEM      = ((r_state == ST_IDLE) & w_access & ~flush) | (r_state == ST_REQ);
    assign dmem_req       = r_req;
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_wdata     = r_wdata;
    assign dmem_be        = r_be;
    assign load_data_MEM  = r_load_data;
    assign load_valid_MEM = r_load_valid;
    assign timeout_err    = r_timeout_err;
    assign misalign_err   = r_misalign_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit. Covers reset,
//            load extension, store lane steering, wait states, DONE hold,
//            timeout, flush during REQ, async reset mid-request and the
//            MISALIGN_TRAP_EN option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        pipe_en;
    logic [31:0] addr_MEM;
    logic [31:0] wdata_MEM;
    logic [2:0]  func3_MEM;
    logic        memR_en_MEM;
    logic        memW_en_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data_MEM;
    logic        load_valid_MEM;
    logic        stall_MEM;
    logic        timeout_err;
    logic        misalign_err;

    int n_cmp;
    int n_bad;
    int n_req_issued;
    logic req_prev;

    mem_access_unit #(
        .TIMEOUT_CYCLES(64),
        .TIMEOUT_W     (7)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .pipe_en       (pipe_en),
        .addr_MEM      (addr_MEM),
        .wdata_MEM     (wdata_MEM),
        .func3_MEM     (func3_MEM),
        .memR_en_MEM   (memR_en_MEM),
        .memW_en_MEM   (memW_en_MEM),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .load_data_MEM (load_data_MEM),
        .load_valid_MEM(load_valid_MEM),
        .stall_MEM     (stall_MEM),
        .timeout_err   (timeout_err),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count bus requests by their rising edge, sampled mid-cycle.
    initial begin
        n_req_issued = 0;
        req_prev     = 1'b0;
    end
    always @(negedge clk) begin
        if (dmem_req && !req_prev) n_req_issued = n_req_issued + 1;
        req_prev = dmem_req;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp_data);
        func3_MEM = f3; addr_MEM = a; memR_en_MEM = 1'b1; memW_en_MEM = 1'b0;
        step();
        chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
        chk({tag, "_be_we"}, {27'h0, dmem_we, dmem_be}, 32'h0000_000F);
        dmem_ack = 1'b1; dmem_rdata = rd;
        step();
        dmem_ack = 1'b0;
        chk({tag, "_data"}, load_data_MEM, exp_data);
        chk({tag, "_valid"}, {31'h0, load_valid_MEM}, 32'h1);
        pipe_en = 1'b1; memR_en_MEM = 1'b0;
        step();
        pipe_en = 1'b0;
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd);
        func3_MEM = f3; addr_MEM = a; wdata_MEM = wd; memW_en_MEM = 1'b1; memR_en_MEM = 1'b0;
        step();
        chk({tag, "_be_we"}, {27'h0, dmem_we, dmem_be}, {27'h0, 1'b1, exp_be});
        chk({tag, "_wdata"}, dmem_wdata, exp_wd);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk({tag, "_done"}, {30'h0, dmem_req, load_valid_MEM}, 32'h0);
        pipe_en = 1'b1; memW_en_MEM = 1'b0;
        step();
        pipe_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_hi;
        int req_base;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; flush = 1'b0; pipe_en = 1'b0; addr_MEM = 32'h0; wdata_MEM = 32'h0;
        func3_MEM = 3'b000; memR_en_MEM = 1'b0; memW_en_MEM = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        step();
        step();
        chk("reset_outs", {26'h0, dmem_req, dmem_we, stall_MEM, load_valid_MEM, timeout_err, misalign_err}, 32'h0);
        chk("reset_data", load_data_MEM, 32'h0);
        chk("reset_bus", dmem_addr | dmem_wdata | {28'h0, dmem_be}, 32'h0);
        rst = 1'b0;
        step();

        // LB 0x1003: two stall cycles, sign-extended top byte.
        func3_MEM = 3'b000; addr_MEM = 32'h0000_1003; memR_en_MEM = 1'b1;
        #1;
        chk("lb_stall_idle", {31'h0, stall_MEM}, 32'h1);
        step();
        chk("lb_req", {31'h0, dmem_req}, 32'h1);
        chk("lb_addr", dmem_addr, 32'h0000_1000);
        chk("lb_be_we", {27'h0, dmem_we, dmem_be}, 32'h0000_000F);
        chk("lb_stall_req", {31'h0, stall_MEM}, 32'h1);
        dmem_ack = 1'b1; dmem_rdata = 32'h8012_3456;
        step();
        dmem_ack = 1'b0;
        chk("lb_stall_done", {30'h0, stall_MEM, dmem_req}, 32'h0);
        chk("lb_data", load_data_MEM, 32'hFFFF_FF80);
        chk("lb_valid", {31'h0, load_valid_MEM}, 32'h1);
        pipe_en = 1'b1; memR_en_MEM = 1'b0;
        step();
        pipe_en = 1'b0;
        chk("lb_valid_clear", {31'h0, load_valid_MEM}, 32'h0);

        // SH 0x2002 with three wait states.
        func3_MEM = 3'b001; addr_MEM = 32'h0000_2002; wdata_MEM = 32'h0000_BEEF; memW_en_MEM = 1'b1;
        step();
        chk("sh_be_we", {27'h0, dmem_we, dmem_be}, 32'h0000_001C);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", dmem_addr, 32'h0000_2000);
        n_hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (dmem_req && stall_MEM && dmem_be == 4'b1100) n_hi++;
            step();
        end
        chk("sh_wait_held", n_hi, 3);
        chk("sh_req_before_ack", {31'h0, dmem_req}, 32'h1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("sh_done", {29'h0, dmem_req, stall_MEM, load_valid_MEM}, 32'h0);
        pipe_en = 1'b1; memW_en_MEM = 1'b0;
        step();
        pipe_en = 1'b0;

        // LHU 0x10: result held in DONE while EX/MEM stays put.
        req_base = n_req_issued;
        func3_MEM = 3'b101; addr_MEM = 32'h0000_0010; memR_en_MEM = 1'b1;
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'h8001_FFFE;
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        chk("lhu_data", load_data_MEM, 32'h0000_FFFE);
        step();
        step();
        chk("lhu_held", load_data_MEM, 32'h0000_FFFE);
        chk("lhu_held_flags", {29'h0, dmem_req, stall_MEM, load_valid_MEM}, 32'h1);
        chk("lhu_one_req", n_req_issued - req_base, 1);
        pipe_en = 1'b1; memR_en_MEM = 1'b0;
        step();
        pipe_en = 1'b0;

        // Remaining lane/extension vectors.
        run_load("lbu", 3'b100, 32'h0000_1001, 32'h1234_F6AB, 32'h0000_00F6);
        run_load("lh_hi", 3'b001, 32'h0000_6002, 32'h8001_7FFF, 32'hFFFF_8001);
        run_load("lw_f110", 3'b110, 32'h0000_7000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_store("sb", 3'b000, 32'h0000_5001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        run_store("sw", 3'b010, 32'h0000_8004, 32'h1234_5678, 4'b1111, 32'h1234_5678);

        // Timeout: no ack for 64 REQ cycles.
        func3_MEM = 3'b010; addr_MEM = 32'h0000_0040; memR_en_MEM = 1'b1;
        step();
        n_hi = 0;
        for (int i = 0; i < 64; i++) begin
            if (dmem_req) n_hi++;
            if (i < 63) step();
        end
        chk("tmo_req_cycles", n_hi, 64);
        step();
        chk("tmo_flags", {28'h0, dmem_req, load_valid_MEM, timeout_err, stall_MEM}, 32'h2);
        chk("tmo_data", load_data_MEM, 32'h0);
        pipe_en = 1'b1; memR_en_MEM = 1'b0;
        step();
        pipe_en = 1'b0;
        chk("tmo_clear", {31'h0, timeout_err}, 32'h0);

        // Flush during REQ: request stays until ack, then straight to IDLE.
        func3_MEM = 3'b010; addr_MEM = 32'h0000_0050; memR_en_MEM = 1'b1;
        step();
        flush = 1'b1; memR_en_MEM = 1'b0;
        step();
        flush = 1'b0;
        chk("flush_req_held", {30'h0, dmem_req, load_valid_MEM}, 32'h2);
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        step();
        dmem_ack = 1'b0;
        chk("flush_idle", {27'h0, dmem_req, stall_MEM, load_valid_MEM, timeout_err, misalign_err}, 32'h0);
        step();
        chk("flush_no_valid", {31'h0, load_valid_MEM}, 32'h0);

        // Async reset mid-REQ drops the request without waiting for a clock.
        func3_MEM = 3'b010; addr_MEM = 32'h0000_0060; memR_en_MEM = 1'b1;
        step();
        chk("rst_req_up", {31'h0, dmem_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_req_drop", {31'h0, dmem_req}, 32'h0);
        memR_en_MEM = 1'b0;
        step();
        rst = 1'b0;
        step();

`ifdef MISALIGN_TRAP_EN
        // Misaligned LW traps without touching the bus.
        req_base = n_req_issued;
        func3_MEM = 3'b010; addr_MEM = 32'h0000_3002; memR_en_MEM = 1'b1;
        #1;
        chk("mis_stall_idle", {31'h0, stall_MEM}, 32'h1);
        step();
        chk("mis_flags", {28'h0, dmem_req, stall_MEM, misalign_err, load_valid_MEM}, 32'h2);
        chk("mis_data", load_data_MEM, 32'h0);
        chk("mis_no_req", n_req_issued - req_base, 0);
        pipe_en = 1'b1; memR_en_MEM = 1'b0;
        step();
        pipe_en = 1'b0;
        chk("mis_clear", {31'h0, misalign_err}, 32'h0);
`else
        // Without the trap a misaligned half uses addr[1] only.
        run_load("lh_mis", 3'b001, 32'h0000_3003, 32'h9ABC_1234, 32'hFFFF_9ABC);
        chk("mis_tied_low", {31'h0, misalign_err}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
